mem_access_stage: RTL
=====================

# mem_access_stage

Memory-access (MEM) stage of the 5-stage MIPS pipeline, between the EX/MEM state register and the MEM/WB state register. Performs byte/halfword/word loads and stores on a request/acknowledge data-memory bus and stalls the upstream pipeline while an access is outstanding. It emits bubbles to MEM/WB during the stall and presents formatted load data plus control on completion.

## Interface
- MAX_WAIT, 255, max cycles `dmem_req` is held without `dmem_ack` before timeout (≥2)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- mem_read_in / mem_write_in  in  1/1  load / store request from EX/MEM
- mem_size_in  in  2  00 byte, 01 half, 10 or 11 word
- mem_unsigned_in  in  1  1 = zero-extend loads, 0 = sign-extend
- alu_result_in  in  32  effective address / ALU result
- write_data_in  in  32  store data (rt), right-aligned
- regwrite_in, memtoreg_in  in  1  WB controls
- write_reg_in  in  5  destination register
- regwrite_out, memtoreg_out, mem_read_out  out  1  to MEM/WB
- alu_result_out  out  32  to MEM/WB
- write_reg_out  out  5  to MEM/WB
- read_data_out  out  32  formatted load data to MEM/WB
- stall_out  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- align_err  out  1  misaligned access this cycle
- timeout_err  out  1  one-cycle pulse on bus timeout
- dmem_req, dmem_we  out  1  bus request / write enable (registered)
- dmem_addr  out  32  word address, bits[1:0]=00 (registered)
- dmem_be  out  4  byte enables (registered)
- dmem_wdata  out  32  lane-replicated store data (registered)
- dmem_rdata  in  32  read data, valid with ack
- dmem_ack  in  1  one-cycle completion strobe

## Operation
- Access = mem_read_in | mem_write_in; both high treated as load.
- Misaligned: half with addr[0]=1, word with addr[1:0]≠00. No bus activity, no stall, align_err=1 that cycle, outputs are a bubble.
- Little-endian lanes. Byte: be=1<<addr[1:0], wdata={4{byte}}. Half: be=addr[1]?1100:0011, wdata={2{half}}. Word: be=1111.
- Load formatting: select lane by addr[1:0]/size, extend per mem_unsigned_in. Stores capture 0 as read data.
- FSM states IDLE, BUSY, DONE:
  - IDLE, no access: combinational pass-through of control/alu/write_reg. read_data_out=0, stall_out=0.
  - IDLE, aligned access: register addr/be/we/wdata, dmem_req←1, wait counter←0, go to BUSY. stall_out=1, bubble out.
  - BUSY: bus fields stable, stall_out=1, bubble out. On ack: capture formatted dmem_rdata into rdata_q, dmem_req←0, go to DONE. If no ack and counter==MAX_WAIT-1: dmem_req←0, rdata_q←0, timeout_err←1, go to DONE. Otherwise counter++. Ack on the timeout cycle wins; no timeout_err.
  - DONE: stall_out=0. Pass through held upstream control with read_data_out=rdata_q. Go to IDLE; timeout_err clears.
- Bubble = regwrite_out=0, memtoreg_out=0, mem_read_out=0, read_data_out=0. alu_result_out and write_reg_out pass through.

## Timing
- Reset (async, low): state IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0, dmem_wdata=0, rdata_q=0, counter=0, timeout_err=0. Combinational outputs follow the IDLE rules.
- Access arriving in cycle T: dmem_req high from T+1. With ack in T+1, DONE is in T+2 and MEM/WB captures at the end of T+2.
  - stall_out is high in T and T+1.
  - Minimum load/store latency is 3 cycles; each extra wait cycle adds 1.
- Back-to-back accesses: the next access is seen in IDLE in the cycle after DONE, with no dead cycle.
- Reset mid-BUSY drops dmem_req immediately. The slave must tolerate an abandoned request.
- Timeout: dmem_req is held exactly MAX_WAIT cycles; timeout_err is high during DONE.

## Test plan
- lw, addr 0x100, ack on first req cycle, rdata 0xDEADBEEF: stall 2 cycles, dmem_be=1111, read_data_out=0xDEADBEEF with regwrite_out=1 in cycle T+2.
- lb, addr 0x103, rdata 0x80_00_00_00: signed → 0xFFFFFF80; lbu → 0x00000080.
- sh 0x1234ABCD to 0x202: dmem_we=1, be=1100, wdata=0xABCDABCD, addr=0x200.
- lw at 0x101: align_err=1, no dmem_req, stall_out=0, regwrite_out=0.
- MAX_WAIT=4, no ack: req high 4 cycles, timeout_err=1 in DONE, read_data_out=0. Ack on the 4th cycle → normal completion, no timeout_err.
- Assert reset in BUSY: dmem_req=0 and stall_out follows IDLE rules immediately. After release, a new lw completes normally.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline: byte/half/word loads and stores over a
// req/ack data-memory bus, stalling upstream until the access completes or times out.
module mem_access_stage #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [1:0]  mem_size_in,
    input  logic        mem_unsigned_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] write_data_in,
    input  logic        regwrite_in,
    input  logic        memtoreg_in,
    input  logic [4:0]  write_reg_in,
    output logic        regwrite_out,
    output logic        memtoreg_out,
    output logic        mem_read_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  write_reg_out,
    output logic [31:0] read_data_out,
    output logic        stall_out,
    output logic        align_err,
    output logic        timeout_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack
);

    localparam int CW = $clog2(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t         state, state_next;
    logic [CW-1:0]  wait_cnt;
    logic [31:0]    rdata_q;
    logic [1:0]     off_q;
    logic [1:0]     size_q;
    logic           uns_q;
    logic           load_q;

    logic           access;
    logic           misaligned;
    logic           start;
    logic           expire;
    logic [3:0]     be_next;
    logic [31:0]    wdata_next;

    // Picks the addressed lane out of the bus word and extends it to 32 bits.
    function automatic logic [31:0] format_load(
        input logic [31:0] raw,
        input logic [1:0]  off,
        input logic [1:0]  size,
        input logic        uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = raw[7:0];
            2'd1:    b = raw[15:8];
            2'd2:    b = raw[23:16];
            default: b = raw[31:24];
        endcase
        h = off[1] ? raw[31:16] : raw[15:0];
        case (size)
            2'b00:   format_load = uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   format_load = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: format_load = raw;
        endcase
    endfunction

    assign access = mem_read_in | mem_write_in;
    assign start  = (state == IDLE) && access && !misaligned;
    assign expire = (state == BUSY) && !dmem_ack && (wait_cnt == CW'(MAX_WAIT - 1));

    // NOTE: every comb output gets a default before the case so no latch is inferred.
    always_comb begin
        misaligned = 1'b0;
        be_next    = 4'b1111;
        wdata_next = write_data_in;
        case (mem_size_in)
            2'b00: begin
                be_next    = 4'b0001 << alu_result_in[1:0];
                wdata_next = {4{write_data_in[7:0]}};
            end
            2'b01: begin
                misaligned = alu_result_in[0];
                be_next    = alu_result_in[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{write_data_in[15:0]}};
            end
            default: misaligned = |alu_result_in[1:0];
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = BUSY;
            BUSY:    if (dmem_ack || expire) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus registers hold their values through BUSY so the slave sees stable fields.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_be     <= '0;
            dmem_wdata  <= '0;
            rdata_q     <= '0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
            off_q       <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            load_q      <= 1'b0;
        end else begin
            timeout_err <= expire;
            case (state)
                IDLE: begin
                    if (start) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= mem_write_in & ~mem_read_in;
                        dmem_addr  <= {alu_result_in[31:2], 2'b00};
                        dmem_be    <= be_next;
                        dmem_wdata <= wdata_next;
                        wait_cnt   <= '0;
                        off_q      <= alu_result_in[1:0];
                        size_q     <= mem_size_in;
                        uns_q      <= mem_unsigned_in;
                        load_q     <= mem_read_in;
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        rdata_q  <= load_q ? format_load(dmem_rdata, off_q, size_q, uns_q) : 32'h0;
                    end else if (expire) begin
                        dmem_req <= 1'b0;
                        rdata_q  <= 32'h0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        regwrite_out   = 1'b0;
        memtoreg_out   = 1'b0;
        mem_read_out   = 1'b0;
        read_data_out  = 32'h0;
        stall_out      = 1'b0;
        align_err      = 1'b0;
        alu_result_out = alu_result_in;
        write_reg_out  = write_reg_in;
        case (state)
            IDLE: begin
                if (!access) begin
                    regwrite_out = regwrite_in;
                    memtoreg_out = memtoreg_in;
                    mem_read_out = mem_read_in;
                end else if (misaligned) begin
                    align_err = 1'b1;
                end else begin
                    stall_out = 1'b1;
                end
            end
            BUSY: stall_out = 1'b1;
            DONE: begin
                // Upstream was frozen, so the inputs still carry this instruction.
                regwrite_out  = regwrite_in;
                memtoreg_out  = memtoreg_in;
                mem_read_out  = mem_read_in;
                read_data_out = rdata_q;
            end
            default: ;
        endcase
    end

endmodule
